key_sched: RTL and testbench

KEY_SCHED -- requirements
Module: key_sched

---
 rtl/arc4_pkg.sv | 15 +
 rtl/key_sched_step.sv | 15 +
 rtl/key_sched.sv | 175 +++++++++++++++++
 tb/tb_key_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared types for the key search scheduler: key width and scheduler state encoding.
package arc4_pkg;

    localparam int unsigned KEY_W = 24;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LAUNCH,
        RUN,
        CHECK,
        DONE
    } key_sched_state_t;

endpackage

// File: rtl/key_sched_step.sv
// Next-key adder for key_sched; wrap flags a carry out of the key width.
module key_step
    import arc4_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [KEY_W-1:0] stride,
    output logic [KEY_W-1:0] next_key,
    output logic             wrap
);

    always_comb begin
        {wrap, next_key} = {1'b0, key} + {1'b0, stride};
    end

endmodule

// File: rtl/key_sched.sv
// Brute-force key search scheduler driving a single decrypt core.
// Optional watchdog on each core run: define KEY_SCHED_TIMEOUT_EN.
module key_sched
    import arc4_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_START      = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_STRIDE     = 24'h000001,
    parameter logic [15:0]      TIMEOUT_CYCLES = 16'd4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    input  logic             abort,
    output logic             key_found,
    output logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] keys_tried,
`ifdef KEY_SCHED_TIMEOUT_EN
    output logic             timeout_err,
`endif
    output logic             core_en,
    input  logic             core_rdy,
    output logic [KEY_W-1:0] core_key,
    input  logic             core_key_fail
);

    key_sched_state_t state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [KEY_W-1:0] core_key_q, core_key_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             found_q, found_d;
    logic [KEY_W-1:0] tried_q, tried_d;
    logic             abort_q, abort_d;
    logic             first_q, first_d;
    logic             fail_q, fail_d;
    logic [KEY_W-1:0] next_key;
    logic             wrap;
`ifdef KEY_SCHED_TIMEOUT_EN
    logic [15:0]      tmo_cnt_q, tmo_cnt_d;
    logic             tmo_err_q, tmo_err_d;
`endif

    key_step u_step (
        .key      (core_key_q),
        .stride   (KEY_STRIDE),
        .next_key (next_key),
        .wrap     (wrap)
    );

    always_comb begin
        state_d    = state_q;
        rdy_d      = rdy_q;
        core_key_d = core_key_q;
        key_d      = key_q;
        found_d    = found_q;
        tried_d    = tried_q;
        abort_d    = abort_q | (abort && (state_q != IDLE));
        first_d    = first_q;
        fail_d     = fail_q;
        core_en    = 1'b0;
`ifdef KEY_SCHED_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        tmo_err_d  = tmo_err_q;
`endif
        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (rdy_q && en) begin
                    state_d    = ISSUE;
                    rdy_d      = 1'b0;
                    core_key_d = KEY_START;
                    tried_d    = '0;
                    found_d    = 1'b0;
`ifdef KEY_SCHED_TIMEOUT_EN
                    tmo_err_d  = 1'b0;
`endif
                end
            end
            ISSUE: begin
                if (core_rdy) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                core_en = 1'b1;
                first_d = 1'b1;
                state_d = RUN;
`ifdef KEY_SCHED_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            RUN: begin
                // The core still shows rdy=1 in the first RUN cycle; its verdict only counts after that.
                first_d = 1'b0;
`ifdef KEY_SCHED_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                if (!first_q && core_rdy) begin
                    fail_d  = core_key_fail;
                    state_d = CHECK;
                end
`ifdef KEY_SCHED_TIMEOUT_EN
                else if (tmo_cnt_d == TIMEOUT_CYCLES) begin
                    tmo_err_d = 1'b1;
                    found_d   = 1'b0;
                    state_d   = DONE;
                end
`endif
            end
            CHECK: begin
                tried_d = tried_q + 24'd1;
                if (!fail_q) begin
                    key_d   = core_key_q;
                    found_d = 1'b1;
                    state_d = DONE;
                end else if (wrap || abort_q || abort) begin
                    state_d = DONE;
                end else begin
                    core_key_d = next_key;
                    state_d    = ISSUE;
                end
            end
            DONE: begin
                rdy_d   = 1'b1;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b1;
            core_key_q <= '0;
            key_q      <= '0;
            found_q    <= 1'b0;
            tried_q    <= '0;
            abort_q    <= 1'b0;
            first_q    <= 1'b0;
            fail_q     <= 1'b0;
`ifdef KEY_SCHED_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            tmo_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rdy_q      <= rdy_d;
            core_key_q <= core_key_d;
            key_q      <= key_d;
            found_q    <= found_d;
            tried_q    <= tried_d;
            abort_q    <= abort_d;
            first_q    <= first_d;
            fail_q     <= fail_d;
`ifdef KEY_SCHED_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_err_q  <= tmo_err_d;
`endif
        end
    end

    assign rdy        = rdy_q;
    assign key_found  = found_q;
    assign key        = key_q;
    assign keys_tried = tried_q;
    assign core_key   = core_key_q;
`ifdef KEY_SCHED_TIMEOUT_EN
    assign timeout_err = tmo_err_q;
`endif

endmodule

// File: tb/tb_key_sched.sv
// Self-checking bench for key_sched: behavioural decrypt cores plus an arithmetic search model.
// Define KEY_SCHED_TIMEOUT_EN to also exercise the watchdog instance.
module tb_key_sched;

`ifdef KEY_SCHED_TIMEOUT_EN
    localparam int NI = 4;
`else
    localparam int NI = 3;
`endif
    localparam int RUN_LEN = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en        [NI];
    logic        abort     [NI];
    logic        rdy       [NI];
    logic        key_found [NI];
    logic [23:0] key       [NI];
    logic [23:0] keys_tried[NI];
    logic        core_en   [NI];
    logic [23:0] core_key  [NI];
    logic        crdy      [NI];
    logic        cfail     [NI];
`ifdef KEY_SCHED_TIMEOUT_EN
    logic        timeout_err;
`endif

    // core model state and observation logs
    int          c       [NI];
    logic [23:0] ckey    [NI];
    logic [23:0] tgt     [NI];
    logic        hang    [NI];
    logic        clr     [NI];
    int          pulses  [NI];
    int          nseen   [NI];
    logic [23:0] seen    [NI][16];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    key_sched u0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .abort(abort[0]),
        .key_found(key_found[0]), .key(key[0]), .keys_tried(keys_tried[0]),
`ifdef KEY_SCHED_TIMEOUT_EN
        .timeout_err(),
`endif
        .core_en(core_en[0]), .core_rdy(crdy[0]), .core_key(core_key[0]), .core_key_fail(cfail[0])
    );

    key_sched #(.KEY_START(24'hFFFFFE), .KEY_STRIDE(24'h000001)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .abort(abort[1]),
        .key_found(key_found[1]), .key(key[1]), .keys_tried(keys_tried[1]),
`ifdef KEY_SCHED_TIMEOUT_EN
        .timeout_err(),
`endif
        .core_en(core_en[1]), .core_rdy(crdy[1]), .core_key(core_key[1]), .core_key_fail(cfail[1])
    );

    key_sched #(.KEY_START(24'hFFFFF9), .KEY_STRIDE(24'h000002)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(rdy[2]), .abort(abort[2]),
        .key_found(key_found[2]), .key(key[2]), .keys_tried(keys_tried[2]),
`ifdef KEY_SCHED_TIMEOUT_EN
        .timeout_err(),
`endif
        .core_en(core_en[2]), .core_rdy(crdy[2]), .core_key(core_key[2]), .core_key_fail(cfail[2])
    );

`ifdef KEY_SCHED_TIMEOUT_EN
    key_sched #(.TIMEOUT_CYCLES(16'd20)) u3 (
        .clk(clk), .rst_n(rst_n), .en(en[3]), .rdy(rdy[3]), .abort(abort[3]),
        .key_found(key_found[3]), .key(key[3]), .keys_tried(keys_tried[3]),
        .timeout_err(timeout_err),
        .core_en(core_en[3]), .core_rdy(crdy[3]), .core_key(core_key[3]), .core_key_fail(cfail[3])
    );
`endif

    // Decrypt core: rdy drops the cycle after en, stays low RUN_LEN cycles, then reports the verdict.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                crdy[i]  <= 1'b1;
                cfail[i] <= 1'b1;
                c[i]     <= 0;
                ckey[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (clr[i]) begin
                    pulses[i] <= 0;
                    nseen[i]  <= 0;
                end else if (core_en[i]) begin
                    pulses[i] <= pulses[i] + 1;
                    if (nseen[i] < 16) seen[i][nseen[i]] <= core_key[i];
                    nseen[i] <= nseen[i] + 1;
                end
                if (core_en[i] && crdy[i]) begin
                    c[i]    <= 1;
                    ckey[i] <= core_key[i];
                end else if (c[i] != 0) begin
                    if (c[i] == 1) crdy[i] <= 1'b0;
                    if (c[i] == RUN_LEN + 1 && !hang[i]) begin
                        crdy[i]  <= 1'b1;
                        cfail[i] <= (ckey[i] != tgt[i]);
                        c[i]     <= 0;
                    end else begin
                        c[i] <= c[i] + 1;
                    end
                end
            end
        end
    end

    // Reference search: walk start, start+stride, ... applying found / exhausted / aborted in that order.
    function automatic void ref_search(input logic [23:0] start, input logic [23:0] stride,
                                       input logic [23:0] target, input int abort_run,
                                       output logic found, output logic [23:0] fkey, output int runs);
        longint k;
        k     = longint'(start);
        runs  = 0;
        found = 1'b0;
        fkey  = '0;
        while (runs < 100000) begin
            runs++;
            if (k == longint'(target)) begin
                found = 1'b1;
                fkey  = 24'(k);
                break;
            end
            if (k + longint'(stride) >= 64'd16777216) break;
            if (abort_run != 0 && runs >= abort_run) break;
            k = k + longint'(stride);
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input int i);
        clr[i] = 1'b1;
        en[i]  = 1'b1;
        tick();
        clr[i] = 1'b0;
        en[i]  = 1'b0;
    endtask

    task automatic wait_done(input int i, input int bound, input string tag, output int cycles);
        cycles = 0;
        while (rdy[i] !== 1'b1 && cycles < bound) begin
            tick();
            cycles++;
        end
        check({tag, "_done"}, {31'd0, rdy[i]}, 32'd1);
    endtask

    task automatic wait_pulses(input int i, input int n, input int bound, input string tag);
        int w;
        w = 0;
        while (pulses[i] < n && w < bound) begin
            tick();
            w++;
        end
        check({tag, "_launch"}, {31'd0, pulses[i] >= n}, 32'd1);
    endtask

    task automatic check_result(input int i, input string tag, input logic found,
                                input logic [23:0] fkey, input int runs);
        check({tag, "_found"}, {31'd0, key_found[i]}, {31'd0, found});
        if (found) check({tag, "_key"}, {8'd0, key[i]}, {8'd0, fkey});
        check({tag, "_tried"}, {8'd0, keys_tried[i]}, 32'(runs));
        check({tag, "_pulses"}, 32'(pulses[i]), 32'(runs));
        check({tag, "_rdy"}, {31'd0, rdy[i]}, 32'd1);
    endtask

    initial begin
        logic        e_found;
        logic [23:0] e_key;
        logic [23:0] k_exp;
        int          e_runs;
        int          cyc;
        logic [23:0] t;

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            en[i] = 1'b0; abort[i] = 1'b0; clr[i] = 1'b1; hang[i] = 1'b0; tgt[i] = 24'h000000;
        end
        repeat (3) tick();
        check("rst_rdy", {31'd0, rdy[0]}, 32'd1);
        check("rst_found", {31'd0, key_found[0]}, 32'd0);
        check("rst_tried", {8'd0, keys_tried[0]}, 32'd0);
        check("rst_core_en", {31'd0, core_en[0]}, 32'd0);
        check("rst_core_key", {8'd0, core_key[0]}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) clr[i] = 1'b0;
        tick();

        // target 3, with a stray en mid-search that must be ignored
        tgt[0] = 24'h000003;
        start(0);
        repeat (20) tick();
        en[0] = 1'b1;
        tick();
        en[0] = 1'b0;
        wait_done(0, 2000, "t3", cyc);
        ref_search(24'h0, 24'h1, tgt[0], 0, e_found, e_key, e_runs);
        check_result(0, "t3", e_found, e_key, e_runs);
        repeat (5) tick();
        check("t3_hold_key", {8'd0, key[0]}, 32'h3);
        check("t3_hold_tried", {8'd0, keys_tried[0]}, 32'd4);

        // randomized targets near the start of the key space
        for (int r = 0; r < 3; r++) begin
            t = 24'($urandom_range(1, 12));
            tgt[0] = t;
            start(0);
            wait_done(0, 3000, "rnd", cyc);
            ref_search(24'h0, 24'h1, t, 0, e_found, e_key, e_runs);
            check_result(0, $sformatf("rnd%0d", r), e_found, e_key, e_runs);
        end

        // abort during run 3: run completes, nothing relaunched
        tgt[0] = 24'h000100;
        start(0);
        wait_pulses(0, 3, 200, "abort");
        repeat (4) tick();
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        wait_done(0, 2000, "abort", cyc);
        ref_search(24'h0, 24'h1, tgt[0], 3, e_found, e_key, e_runs);
        check_result(0, "abort", e_found, e_key, e_runs);

        // exhaustion from 0xFFFFFE, then the last key being the target
        tgt[1] = 24'h000005;
        start(1);
        wait_done(1, 2000, "exh", cyc);
        ref_search(24'hFFFFFE, 24'h1, tgt[1], 0, e_found, e_key, e_runs);
        check_result(1, "exh", e_found, e_key, e_runs);
        tgt[1] = 24'hFFFFFF;
        start(1);
        wait_done(1, 2000, "last", cyc);
        ref_search(24'hFFFFFE, 24'h1, tgt[1], 0, e_found, e_key, e_runs);
        check_result(1, "last", e_found, e_key, e_runs);

        // stride 2 from an odd start never presents the even target
        tgt[2] = 24'h000004;
        start(2);
        wait_done(2, 2000, "odd", cyc);
        ref_search(24'hFFFFF9, 24'h2, tgt[2], 0, e_found, e_key, e_runs);
        check_result(2, "odd", e_found, e_key, e_runs);
        for (int j = 0; j < 4; j++) begin
            k_exp = 24'hFFFFF9 + 24'(2 * j);
            check($sformatf("odd_key%0d", j), {8'd0, seen[2][j]}, {8'd0, k_exp});
            check($sformatf("odd_not4_%0d", j), {31'd0, seen[2][j] != 24'h4}, 32'd1);
        end

        // asynchronous reset in the middle of a run
        tgt[0] = 24'h000050;
        start(0);
        wait_pulses(0, 2, 200, "rst_mid");
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rstm_rdy", {31'd0, rdy[0]}, 32'd1);
        check("rstm_found", {31'd0, key_found[0]}, 32'd0);
        check("rstm_key", {8'd0, key[0]}, 32'd0);
        check("rstm_tried", {8'd0, keys_tried[0]}, 32'd0);
        check("rstm_core_en", {31'd0, core_en[0]}, 32'd0);
        check("rstm_core_key", {8'd0, core_key[0]}, 32'd0);
`ifdef KEY_SCHED_TIMEOUT_EN
        check("rstm_timeout", {31'd0, timeout_err}, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        tgt[0] = 24'h000002;
        start(0);
        wait_done(0, 2000, "post_rst", cyc);
        ref_search(24'h0, 24'h1, tgt[0], 0, e_found, e_key, e_runs);
        check_result(0, "post_rst", e_found, e_key, e_runs);

`ifdef KEY_SCHED_TIMEOUT_EN
        // core never re-raises rdy: watchdog ends the search after 20 RUN cycles
        hang[3] = 1'b1;
        tgt[3]  = 24'h000000;
        start(3);
        wait_done(3, 500, "tmo", cyc);
        check("tmo_err", {31'd0, timeout_err}, 32'd1);
        check("tmo_found", {31'd0, key_found[3]}, 32'd0);
        check("tmo_pulses", 32'(pulses[3]), 32'd1);
        check("tmo_tried", {8'd0, keys_tried[3]}, 32'd0);
        check("tmo_min_cycles", {31'd0, cyc >= 20}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
